// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    // Width of one BCD digit.
    localparam int unsigned DigitW = 4;

    // Digit value driven on every output nibble when the result overflows.
    localparam logic [DigitW-1:0] NineNibble = 4'h9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DigitW-1:0] digit_in,
    output logic [DigitW-1:0] digit_out
);

    // Combinational adjust so the following doubling carries correctly into the next digit.
    always_comb begin
        digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake
// and an auto mode that reconverts whenever the input value changes.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         bin_in,
    input  logic                     start,
    input  logic                     auto_en,
    output logic                     busy,
    output logic                     done,
    output logic [DigitW*DIGITS-1:0] bcd_out,
    output logic                     neg,
    output logic                     overflow
);

    localparam int unsigned BcdW = DigitW * DIGITS;
    // One spare bit above the top digit catches a carry out of the last nibble.
    localparam int unsigned ScrW = BcdW + 1;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [ScrW-1:0]   scr_q, scr_d;
    logic              sticky_q, sticky_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic              neg_pend_q, neg_pend_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic              launch;
    logic              neg_in;
    logic [WIDTH-1:0]  mag_in;
    logic [BcdW-1:0]   adj;
    logic [ScrW-1:0]   scr_shift;
    logic              ovf_fin;

    // Per-digit add-3 correction of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (scr_q[g*DigitW +: DigitW]),
            .digit_out (adj[g*DigitW +: DigitW])
        );
    end

    assign launch    = start | (auto_en & (bin_in != last_q));
    assign neg_in    = SIGNED & bin_in[WIDTH-1];
    assign mag_in    = neg_in ? -bin_in : bin_in;
    // Adjusted digits shifted left with the next magnitude bit entering at the bottom.
    assign scr_shift = {adj, mag_q[WIDTH-1]};
    // Once the spare bit has ever been set the value exceeded the digit range.
    assign ovf_fin   = sticky_q | scr_q[ScrW-1] | scr_shift[ScrW-1];

    // Next-state logic: launch from IDLE/DONE, WIDTH shift steps, result capture on last step.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        scr_d      = scr_q;
        sticky_d   = sticky_q;
        last_d     = last_q;
        neg_pend_d = neg_pend_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (launch) begin
                    state_d    = StShift;
                    cnt_d      = '0;
                    mag_d      = mag_in;
                    scr_d      = '0;
                    sticky_d   = 1'b0;
                    last_d     = bin_in;
                    neg_pend_d = neg_in;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                scr_d    = scr_shift;
                mag_d    = mag_q << 1;
                sticky_d = sticky_q | scr_q[ScrW-1];
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    ovf_d   = ovf_fin;
                    bcd_d   = ovf_fin ? {DIGITS{NineNibble}} : scr_shift[BcdW-1:0];
                    neg_d   = neg_pend_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mag_q      <= '0;
            scr_q      <= '0;
            sticky_q   <= 1'b0;
            last_q     <= '0;
            neg_pend_q <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            scr_q      <= scr_d;
            sticky_q   <= sticky_d;
            last_q     <= last_d;
            neg_pend_q <= neg_pend_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q == StShift);
    assign done     = (state_q == StDone);
    assign bcd_out  = bcd_q;
    assign neg      = neg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: three converter configurations share one stimulus stream and are
// compared every cycle against a timestamp/arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int W = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  bin_in;
    logic          start;
    logic          auto_en;

    logic          busy0, done0, neg0, ovf0;
    logic [15:0]   bcd0;
    logic          busy1, done1, neg1, ovf1;
    logic [15:0]   bcd1;
    logic          busy2, done2, neg2, ovf2;
    logic [11:0]   bcd2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(13), .DIGITS(4), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .auto_en(auto_en),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .neg(neg0), .overflow(ovf0)
    );

    bin_to_bcd_seq #(.WIDTH(13), .DIGITS(4), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .auto_en(auto_en),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .neg(neg1), .overflow(ovf1)
    );

    bin_to_bcd_seq #(.WIDTH(13), .DIGITS(3), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start), .auto_en(auto_en),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .neg(neg2), .overflow(ovf2)
    );

    // Actual outputs gathered per instance.
    logic [15:0] act_bcd  [3];
    logic        act_busy [3];
    logic        act_done [3];
    logic        act_neg  [3];
    logic        act_ovf  [3];
    assign act_bcd[0] = bcd0;  assign act_bcd[1] = bcd1;  assign act_bcd[2] = {4'h0, bcd2};
    assign act_busy[0] = busy0; assign act_busy[1] = busy1; assign act_busy[2] = busy2;
    assign act_done[0] = done0; assign act_done[1] = done1; assign act_done[2] = done2;
    assign act_neg[0] = neg0;  assign act_neg[1] = neg1;  assign act_neg[2] = neg2;
    assign act_ovf[0] = ovf0;  assign act_ovf[1] = ovf1;  assign act_ovf[2] = ovf2;

    // Reference model state: launch edge timestamp plus pending/visible results.
    int          digs [3] = '{4, 4, 3};
    bit          sgn  [3] = '{1'b0, 1'b1, 1'b0};
    int          m_k  [3];
    logic [W-1:0] m_last [3];
    logic [15:0] m_pbcd [3], m_bcd [3];
    bit          m_pneg [3], m_neg [3], m_povf [3], m_ovf [3];

    function automatic int unsigned pow10(input int n);
        int unsigned r = 1;
        for (int j = 0; j < n; j++) r = r * 10;
        return r;
    endfunction

    // Decimal conversion of the value from plain arithmetic.
    function automatic void convert(input logic [W-1:0] v, input int d, input bit s,
                                    output logic [15:0] b, output bit n, output bit o);
        int unsigned mag;
        mag = int'(v);
        n = 1'b0;
        if (s && v[W-1]) begin
            mag = 8192 - int'(v);
            n = 1'b1;
        end
        o = (mag >= pow10(d));
        b = '0;
        for (int j = 0; j < d; j++) begin
            b[4*j +: 4] = o ? 4'd9 : 4'((mag / pow10(j)) % 10);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model update on each rising edge, from the same stable inputs the DUTs see.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_k[i] = -1000;
                m_last[i] = '0;
                m_bcd[i] = '0;
                m_neg[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end else begin
                if (cyc == m_k[i] + W) begin
                    m_bcd[i] = m_pbcd[i];
                    m_neg[i] = m_pneg[i];
                    m_ovf[i] = m_povf[i];
                end
                if (!((cyc > m_k[i]) && (cyc <= m_k[i] + W)) &&
                    (start || (auto_en && (bin_in != m_last[i])))) begin
                    m_k[i] = cyc;
                    m_last[i] = bin_in;
                    convert(bin_in, digs[i], sgn[i], m_pbcd[i], m_pneg[i], m_povf[i]);
                end
            end
        end
    end

    // Per-cycle compare, mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("i%0d_busy c%0d", i, cyc), 32'(act_busy[i]),
                      32'((cyc >= m_k[i]) && (cyc < m_k[i] + W)));
                check($sformatf("i%0d_done c%0d", i, cyc), 32'(act_done[i]),
                      32'(cyc == m_k[i] + W));
                check($sformatf("i%0d_bcd c%0d", i, cyc), 32'(act_bcd[i]), 32'(m_bcd[i]));
                check($sformatf("i%0d_neg c%0d", i, cyc), 32'(act_neg[i]), 32'(m_neg[i]));
                check($sformatf("i%0d_ovf c%0d", i, cyc), 32'(act_ovf[i]), 32'(m_ovf[i]));
            end
            if (done0 === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a conversion and wait (bounded) for the done cycle.
    task automatic do_conv(input logic [W-1:0] v, output int lat, output int busy_cyc);
        bin_in = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (done0 !== 1'b1 && lat < 40) begin
            if (busy0 === 1'b1) busy_cyc++;
            tick();
            lat++;
        end
        if (done0 !== 1'b1) check("done_timeout", 32'(done0), 32'd1);
    endtask

    initial begin
        int lat, bc, dc;
        reset = 1'b1;
        start = 1'b0;
        auto_en = 1'b0;
        bin_in = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_bcd", 32'(bcd0), 32'h0);
        check("rst_flags", 32'({neg0, ovf0}), 32'd0);
        tick();

        // 1234: latency, busy length and result in all three configurations.
        do_conv(13'd1234, lat, bc);
        check("lat_1234", 32'(lat), 32'd14);
        check("busy_len_1234", 32'(bc), 32'd13);
        check("bcd_1234", 32'(bcd0), 32'h1234);
        check("flags_1234", 32'({neg0, ovf0}), 32'd0);
        check("d3_ovf_1234", 32'(ovf2), 32'd1);
        check("d3_bcd_1234", 32'(bcd2), 32'h999);
        tick();

        dc = done_cnt;
        do_conv(13'd0, lat, bc);
        check("bcd_0", 32'(bcd0), 32'h0000);
        tick();
        do_conv(13'd8191, lat, bc);
        check("bcd_8191", 32'(bcd0), 32'h8191);
        check("s_bcd_1fff", 32'(bcd1), 32'h0001);
        check("s_neg_1fff", 32'(neg1), 32'd1);
        tick();
        check("dones_0_8191", 32'(done_cnt - dc), 32'd2);

        // Start during SHIFT with a changed value is ignored.
        dc = done_cnt;
        bin_in = 13'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        bin_in = 13'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("ignored_start_bcd", 32'(bcd0), 32'h0042);
        check("ignored_start_dones", 32'(done_cnt - dc), 32'd1);

        do_conv(13'h1000, lat, bc);
        check("bcd_4096", 32'(bcd0), 32'h4096);
        check("s_bcd_1000", 32'(bcd1), 32'h4096);
        check("s_neg_1000", 32'(neg1), 32'd1);
        tick();

        // Auto mode: 42, held, then 43.
        dc = done_cnt;
        bin_in = 13'd42;
        auto_en = 1'b1;
        repeat (20) tick();
        check("auto_bcd_42", 32'(bcd0), 32'h0042);
        repeat (20) tick();
        bin_in = 13'd43;
        repeat (20) tick();
        check("auto_bcd_43", 32'(bcd0), 32'h0043);
        auto_en = 1'b0;
        check("auto_dones", 32'(done_cnt - dc), 32'd2);
        tick();

        // Reset in the middle of a conversion.
        bin_in = 13'd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_bcd", 32'(bcd0), 32'h0);
        dc = done_cnt;
        repeat (20) tick();
        check("midrst_no_done", 32'(done_cnt - dc), 32'd0);
        do_conv(13'd777, lat, bc);
        check("bcd_777", 32'(bcd0), 32'h0777);
        tick();

        // Randomised traffic, checked every cycle against the model.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 249) == 0);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 9) == 0) bin_in = W'($urandom_range(0, 8191));
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        auto_en = 1'b0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
